// File: rtl/frame_mem_pkg.sv
// Shared definitions for the frame-buffer port-A arbiter: default widths,
// starvation limit and the read-tag owner encoding.
package frame_mem_pkg;

   localparam int AW_DEF         = 16;
   localparam int DW_DEF         = 16;
   localparam int RD_LAT_DEF     = 1;
   localparam int STARVE_MAX_DEF = 4;

   localparam logic OWN_VID = 1'b0;
   localparam logic OWN_GM  = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register carrying {valid, owner} alongside an outstanding block-RAM
// read so the returning data can be steered to the requester that issued it.
module rd_tag_pipe
   import frame_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t r_stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares block-RAM port A between the video scan reader (priority) and the
// game logic, with a starvation counter that forces periodic game slots.
module frame_mem_arbiter
   import frame_mem_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic          vid_rvalid,
   output logic [DW-1:0] vid_rdata,
   input  logic          gm_req,
   input  logic          gm_we,
   input  logic [AW-1:0] gm_addr,
   input  logic [DW-1:0] gm_wdata,
   output logic          gm_gnt,
   output logic          gm_rvalid,
   output logic [DW-1:0] gm_rdata,
   output logic          gm_forced,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam int              CW    = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0]   C_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] r_starveCnt;
   logic          r_memEn;
   logic          r_memWe;
   logic [AW-1:0] r_memAddr;
   logic [DW-1:0] r_memDin;
   logic [DW-1:0] r_vidHold;
   logic [DW-1:0] r_gmHold;

   logic          w_starved;
   logic          w_vidGnt;
   logic          w_gmGnt;
   logic          w_vidRvalid;
   logic          w_gmRvalid;
   rd_tag_t       w_tagIn;
   rd_tag_t       w_tagOut;

   // Grants are gated by reset so nothing is accepted while the block is held.
   assign w_starved = (r_starveCnt == C_MAX);
   assign w_gmGnt   = reset & gm_req & (~vid_req | w_starved);
   assign w_vidGnt  = reset & vid_req & ~w_gmGnt;

   assign vid_gnt   = w_vidGnt;
   assign gm_gnt    = w_gmGnt;
   assign gm_forced = w_gmGnt & vid_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starveCnt <= '0;
      end else if (!gm_req || w_gmGnt) begin
         r_starveCnt <= '0;
      end else if (w_vidGnt && !w_starved) begin
         r_starveCnt <= r_starveCnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_memEn   <= 1'b0;
         r_memWe   <= 1'b0;
         r_memAddr <= '0;
         r_memDin  <= '0;
      end else begin
         r_memEn <= w_vidGnt | w_gmGnt;
         r_memWe <= w_gmGnt & gm_we;
         if (w_vidGnt) begin
            r_memAddr <= vid_addr;
         end else if (w_gmGnt) begin
            r_memAddr <= gm_addr;
         end
         if (w_gmGnt && gm_we) begin
            r_memDin <= gm_wdata;
         end
      end
   end

   assign mem_en   = r_memEn;
   assign mem_we   = r_memWe;
   assign mem_addr = r_memAddr;
   assign mem_din  = r_memDin;

   // Writes carry no tag, so they never produce a read-valid pulse.
   assign w_tagIn.valid = w_vidGnt | (w_gmGnt & ~gm_we);
   assign w_tagIn.owner = w_gmGnt ? OWN_GM : OWN_VID;

   rd_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_tagPipe (
      .clk   (clk),
      .rst_n (reset),
      .i_tag (w_tagIn),
      .o_tag (w_tagOut)
   );

   assign w_vidRvalid = w_tagOut.valid & (w_tagOut.owner == OWN_VID);
   assign w_gmRvalid  = w_tagOut.valid & (w_tagOut.owner == OWN_GM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vidHold <= '0;
         r_gmHold  <= '0;
      end else begin
         if (w_vidRvalid) begin
            r_vidHold <= mem_dout;
         end
         if (w_gmRvalid) begin
            r_gmHold <= mem_dout;
         end
      end
   end

   assign vid_rvalid = w_vidRvalid;
   assign gm_rvalid  = w_gmRvalid;
   assign vid_rdata  = w_vidRvalid ? mem_dout : r_vidHold;
   assign gm_rdata   = w_gmRvalid  ? mem_dout : r_gmHold;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: reference arbiter/memory model
// feeding a scoreboard, a vector table, and hand-written corner sequences.
module tb_frame_mem_arbiter;
   import frame_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        vid_req = 1'b0;
   logic [15:0] vid_addr = '0;
   logic        vid_gnt, vid_rvalid;
   logic [15:0] vid_rdata;
   logic        gm_req = 1'b0, gm_we = 1'b0;
   logic [15:0] gm_addr = '0, gm_wdata = '0;
   logic        gm_gnt, gm_rvalid, gm_forced;
   logic [15:0] gm_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_din, mem_dout;

   frame_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
      .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
      .gm_forced(gm_forced),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Block RAM model with one cycle of read latency.
   logic [15:0] memArr [65536];
   logic [15:0] refMem [65536];
   logic [15:0] memRd = '0;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) memArr[mem_addr] <= mem_din;
         else        memRd <= memArr[mem_addr];
      end
   end
   assign mem_dout = memRd;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int vecCount = 0;
   int missCount = 0;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   typedef struct {
      logic        owner;
      logic [15:0] data;
      int          due;
   } sb_t;
   sb_t sbQ[$];

   bit          sbOn = 0;
   int          refCnt = 0;
   logic        expEn = 0, expWe = 0;
   logic [15:0] expAddr = '0, expDin = '0;
   logic [15:0] refLastVid = '0, refLastGm = '0;
   logic        mV, mG, mF, eRv, eOwner;
   logic [15:0] eData;

   // Reference arbiter, command pipeline and read-return scoreboard.
   always @(negedge clk) begin
      if (sbOn) begin
         mG = gm_req && (!vid_req || refCnt == 4);
         mV = vid_req && !mG;
         mF = mG && vid_req;
         checkOutput("vid_gnt", 16'(vid_gnt), 16'(mV));
         checkOutput("gm_gnt", 16'(gm_gnt), 16'(mG));
         checkOutput("gm_forced", 16'(gm_forced), 16'(mF));
         checkOutput("mem_en", 16'(mem_en), 16'(expEn));
         checkOutput("mem_we", 16'(mem_we), 16'(expWe));
         if (expEn) checkOutput("mem_addr", mem_addr, expAddr);
         if (expWe) checkOutput("mem_din", mem_din, expDin);
         eRv    = (sbQ.size() > 0) && (sbQ[0].due == cycle);
         eOwner = eRv ? sbQ[0].owner : OWN_VID;
         eData  = eRv ? sbQ[0].data : 16'h0;
         if (eRv) begin
            if (eOwner == OWN_VID) refLastVid = eData;
            else                   refLastGm  = eData;
            void'(sbQ.pop_front());
         end
         checkOutput("vid_rvalid", 16'(vid_rvalid), 16'(eRv && eOwner == OWN_VID));
         checkOutput("gm_rvalid", 16'(gm_rvalid), 16'(eRv && eOwner == OWN_GM));
         checkOutput("vid_rdata", vid_rdata, refLastVid);
         checkOutput("gm_rdata", gm_rdata, refLastGm);
         if (!gm_req || mG)           refCnt = 0;
         else if (mV && refCnt < 4)   refCnt = refCnt + 1;
         expEn   = mV || mG;
         expWe   = mG && gm_we;
         expAddr = mV ? vid_addr : gm_addr;
         expDin  = gm_wdata;
         if (mV) sbQ.push_back('{OWN_VID, refMem[vid_addr], cycle + 2});
         if (mG && !gm_we) sbQ.push_back('{OWN_GM, refMem[gm_addr], cycle + 2});
         if (mG && gm_we) refMem[gm_addr] = gm_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic assertReset();
      reset = 1'b0;
      sbOn = 0;
      sbQ.delete();
      refCnt = 0;
      expEn = 0;
      expWe = 0;
      refLastVid = '0;
      refLastGm = '0;
   endtask

   typedef struct {
      logic        vReq, gReq, gWe;
      logic [15:0] vAddr, gAddr, wData;
      logic        expV, expG;
   } vec_t;
   vec_t tbl[7];

   task automatic applyStimulus(input vec_t v);
      tick();
      vid_req = v.vReq; gm_req = v.gReq; gm_we = v.gWe;
      vid_addr = v.vAddr; gm_addr = v.gAddr; gm_wdata = v.wData;
      @(negedge clk);
      checkOutput("tbl vid_gnt", 16'(vid_gnt), 16'(v.expV));
      checkOutput("tbl gm_gnt", 16'(gm_gnt), 16'(v.expG));
      tick();
      vid_req = 0; gm_req = 0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         memArr[i] = 16'(i) ^ 16'h5A5A;
         refMem[i] = 16'(i) ^ 16'h5A5A;
      end
      memArr[16'h0010] = 16'hABCD;
      refMem[16'h0010] = 16'hABCD;

      tbl[0] = '{1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 1, 0};
      tbl[1] = '{0, 1, 1, 16'h0000, 16'h0500, 16'hBEEF, 0, 1};
      tbl[2] = '{0, 1, 0, 16'h0000, 16'h0500, 16'h0000, 0, 1};
      tbl[3] = '{1, 1, 0, 16'h0500, 16'h0600, 16'h0000, 1, 0};
      tbl[4] = '{0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0};
      tbl[5] = '{1, 1, 1, 16'h0031, 16'h0700, 16'h7777, 1, 0};
      tbl[6] = '{1, 0, 0, 16'h0700, 16'h0000, 16'h0000, 1, 0};

      // Reset held with both requests high: everything must stay quiet.
      vid_req = 1; gm_req = 1; vid_addr = 16'h0010; gm_addr = 16'h0040;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst vid_gnt", 16'(vid_gnt), 16'h0);
         checkOutput("rst gm_gnt", 16'(gm_gnt), 16'h0);
         checkOutput("rst gm_forced", 16'(gm_forced), 16'h0);
         checkOutput("rst mem_en", 16'(mem_en), 16'h0);
         checkOutput("rst mem_we", 16'(mem_we), 16'h0);
         checkOutput("rst vid_rvalid", 16'(vid_rvalid), 16'h0);
         checkOutput("rst gm_rvalid", 16'(gm_rvalid), 16'h0);
      end
      tick();
      reset = 1; sbOn = 1;
      @(negedge clk);
      checkOutput("rst first vid_gnt", 16'(vid_gnt), 16'h1);
      tick();
      vid_req = 0; gm_req = 0;
      @(negedge clk);
      checkOutput("rst mem_en after", 16'(mem_en), 16'h1);
      repeat (3) tick();

      for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);
      repeat (3) tick();

      // Single video read with explicit timing.
      vid_req = 1; vid_addr = 16'h0010;
      @(negedge clk);
      checkOutput("svr vid_gnt", 16'(vid_gnt), 16'h1);
      tick();
      vid_req = 0;
      @(negedge clk);
      checkOutput("svr mem_en", 16'(mem_en), 16'h1);
      checkOutput("svr mem_addr", mem_addr, 16'h0010);
      @(negedge clk);
      checkOutput("svr vid_rvalid", 16'(vid_rvalid), 16'h1);
      checkOutput("svr vid_rdata", vid_rdata, 16'hABCD);
      repeat (2) tick();

      // Game write followed immediately by a read of the same address.
      gm_req = 1; gm_we = 1; gm_addr = 16'h0200; gm_wdata = 16'h1234;
      @(negedge clk);
      checkOutput("gwr gm_gnt", 16'(gm_gnt), 16'h1);
      tick();
      gm_we = 0;
      @(negedge clk);
      checkOutput("gwr mem_we", 16'(mem_we), 16'h1);
      checkOutput("gwr mem_din", mem_din, 16'h1234);
      checkOutput("grd gm_gnt", 16'(gm_gnt), 16'h1);
      tick();
      gm_req = 0;
      @(negedge clk);
      checkOutput("gwr no rvalid", 16'(gm_rvalid), 16'h0);
      tick();
      @(negedge clk);
      checkOutput("grd gm_rvalid", 16'(gm_rvalid), 16'h1);
      checkOutput("grd gm_rdata", gm_rdata, 16'h1234);
      repeat (2) tick();

      // Starvation: both held high, expect V,V,V,V,G repeating.
      vid_req = 1; gm_req = 1; gm_we = 0; vid_addr = 16'h0100; gm_addr = 16'h0400;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checkOutput("starve gm_gnt", 16'(gm_gnt), 16'((k % 5) == 4));
         checkOutput("starve forced", 16'(gm_forced), 16'((k % 5) == 4));
         tick();
      end
      vid_req = 0; gm_req = 0;
      repeat (3) tick();

      // Back-to-back alternating video and game reads.
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            vid_req = 1; gm_req = 0; vid_addr = 16'(i);
         end else begin
            vid_req = 0; gm_req = 1; gm_we = 0; gm_addr = 16'h8000 + 16'(i);
         end
         tick();
      end
      vid_req = 0; gm_req = 0;
      repeat (4) tick();

      // Reset lands while a video read is in flight.
      vid_req = 1; vid_addr = 16'h0010;
      @(negedge clk);
      checkOutput("mid vid_gnt", 16'(vid_gnt), 16'h1);
      tick();
      vid_req = 0;
      assertReset();
      repeat (3) begin
         @(negedge clk);
         checkOutput("mid vid_rvalid", 16'(vid_rvalid), 16'h0);
         checkOutput("mid mem_en", 16'(mem_en), 16'h0);
      end
      tick();
      reset = 1; sbOn = 1;
      repeat (4) tick();

      checkOutput("sb drained", 16'(sbQ.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
